// File: rtl/rtc_barrido_lectura.sv
`default_nettype none
// ============================================================================
// Module   : rtc_barrido_lectura
// Purpose  : RTC read sequencer. Sweeps a 6-bit step address 0..ADDR_LAST,
//            runs one multiplexed-bus read per RTC register (slots 1..9) and
//            holds each value on a dedicated output. Offers a hold/ack
//            handshake at slot boundaries so a writer can take the bus.
// Options  : RTC_BCD_CHECK_EN - reject captures with a nibble > 9 and pulse
//            bcd_err instead of loading the output register.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_barrido_lectura #(
    parameter int STEP_DIV  = 16,
    parameter int ADDR_LAST = 55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ale,
    output logic [5:0] addr,
    output logic [7:0] s_l,
    output logic [7:0] m_l,
    output logic [7:0] h_l,
    output logic [7:0] d_l,
    output logic [7:0] me_l,
    output logic [7:0] a_l,
    output logic [7:0] st_l,
    output logic [7:0] mt_l,
    output logic [7:0] ht_l,
    output logic       sweep_done,
    output logic       hold_ack
`ifdef RTC_BCD_CHECK_EN
    ,
    output logic       bcd_err
`endif
);

    localparam logic [7:0] c_div_last  = 8'(STEP_DIV - 1);
    localparam logic [5:0] c_addr_last = 6'(ADDR_LAST);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_div;
    logic [5:0] r_addr;
    logic [7:0] r_ad_out;
    logic       r_ad_oe;
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_ale;
    logic       r_sweep_done;
    logic       r_hold_ack;
    logic [7:0] r_val [0:8];

    logic       w_step_end;
    logic [5:0] w_addr_nxt;
    logic       w_nxt_bound;
    logic [5:0] w_slot;
    logic [5:0] w_phase;
    logic [5:0] w_dec_addr;
    logic [5:0] w_dec_slot;
    logic [5:0] w_dec_phase;
    logic       w_dec_read;
    logic [7:0] w_ad_out;
    logic       w_ad_oe;
    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic       w_ale;
    logic       w_cap;
    logic       w_load;

    // Slot number to RTC register address
    function automatic logic [7:0] f_map(input logic [5:0] slot);
        logic [7:0] v;
        case (slot)
            6'd1:    v = 8'h21;
            6'd2:    v = 8'h22;
            6'd3:    v = 8'h23;
            6'd4:    v = 8'h24;
            6'd5:    v = 8'h25;
            6'd6:    v = 8'h26;
            6'd7:    v = 8'h41;
            6'd8:    v = 8'h42;
            6'd9:    v = 8'h43;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign w_step_end  = (r_state == ST_RUN) && (r_div == c_div_last);
    assign w_addr_nxt  = (r_addr == c_addr_last) ? 6'd0 : r_addr + 6'd1;
    assign w_nxt_bound = ((w_addr_nxt % 6'd5) == 6'd0);
    assign w_slot      = r_addr / 6'd5;
    assign w_phase     = r_addr % 6'd5;

    // Bus outputs are registered, so decode the step that will be current
    // after the next edge: the next address in RUN, the frozen one in HOLD
    // (used on the release edge).
    assign w_dec_addr  = (r_state == ST_HOLD) ? r_addr : w_addr_nxt;
    assign w_dec_slot  = w_dec_addr / 6'd5;
    assign w_dec_phase = w_dec_addr % 6'd5;
    assign w_dec_read  = (w_dec_slot >= 6'd1) && (w_dec_slot <= 6'd9);

    // Phase decode of the upcoming step into bus strobe levels
    always_comb begin
        w_ad_out = 8'h00;
        w_ad_oe  = 1'b0;
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_ale    = 1'b0;
        if (w_dec_read) begin
            case (w_dec_phase)
                6'd0: begin
                    w_cs_n   = 1'b0;
                    w_ale    = 1'b1;
                    w_wr_n   = 1'b0;
                    w_ad_oe  = 1'b1;
                    w_ad_out = f_map(w_dec_slot);
                end
                6'd1: w_cs_n = 1'b0;
                6'd2, 6'd3: begin
                    w_cs_n = 1'b0;
                    w_rd_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Capture happens on the last edge of phase 3 of a read slot
    assign w_cap = w_step_end && (w_phase == 6'd3) &&
                   (w_slot >= 6'd1) && (w_slot <= 6'd9);

`ifdef RTC_BCD_CHECK_EN
    logic w_bcd_ok;
    logic r_bcd_err;

    assign w_bcd_ok = (ad_in[7:4] <= 4'd9) && (ad_in[3:0] <= 4'd9);
    assign w_load   = w_cap && w_bcd_ok;
    assign bcd_err  = r_bcd_err;

    // One-clock error pulse on a rejected capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bcd_err <= 1'b0;
        else     r_bcd_err <= w_cap && !w_bcd_ok;
    end
`else
    assign w_load = w_cap;
`endif

    // Step divider, address sweep, hold handshake and registered bus strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_div        <= 8'd0;
            r_addr       <= 6'd0;
            r_ad_out     <= 8'h00;
            r_ad_oe      <= 1'b0;
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_ale        <= 1'b0;
            r_sweep_done <= 1'b0;
            r_hold_ack   <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_step_end) begin
                        r_div        <= 8'd0;
                        r_addr       <= w_addr_nxt;
                        r_sweep_done <= (r_addr == c_addr_last);
                        if (hold && w_nxt_bound) begin
                            r_state    <= ST_HOLD;
                            r_hold_ack <= 1'b1;
                            r_ad_out   <= 8'h00;
                            r_ad_oe    <= 1'b0;
                            r_cs_n     <= 1'b1;
                            r_rd_n     <= 1'b1;
                            r_wr_n     <= 1'b1;
                            r_ale      <= 1'b0;
                        end else begin
                            r_ad_out <= w_ad_out;
                            r_ad_oe  <= w_ad_oe;
                            r_cs_n   <= w_cs_n;
                            r_rd_n   <= w_rd_n;
                            r_wr_n   <= w_wr_n;
                            r_ale    <= w_ale;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    r_div <= 8'd0;
                    if (!hold) begin
                        r_state    <= ST_RUN;
                        r_hold_ack <= 1'b0;
                        r_ad_out   <= w_ad_out;
                        r_ad_oe    <= w_ad_oe;
                        r_cs_n     <= w_cs_n;
                        r_rd_n     <= w_rd_n;
                        r_wr_n     <= w_wr_n;
                        r_ale      <= w_ale;
                    end
                end
            endcase
        end
    end

    // One holding register per read slot, loaded only on its capture edge
    for (genvar gi = 0; gi < 9; gi++) begin : g_val
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                  r_val[gi] <= 8'h00;
            else if (w_load && (w_slot == 6'(gi + 1))) r_val[gi] <= ad_in;
        end
    end

    assign ad_out     = r_ad_out;
    assign ad_oe      = r_ad_oe;
    assign cs_n       = r_cs_n;
    assign rd_n       = r_rd_n;
    assign wr_n       = r_wr_n;
    assign ale        = r_ale;
    assign addr       = r_addr;
    assign sweep_done = r_sweep_done;
    assign hold_ack   = r_hold_ack;
    assign s_l        = r_val[0];
    assign m_l        = r_val[1];
    assign h_l        = r_val[2];
    assign d_l        = r_val[3];
    assign me_l       = r_val[4];
    assign a_l        = r_val[5];
    assign st_l       = r_val[6];
    assign mt_l       = r_val[7];
    assign ht_l       = r_val[8];

endmodule
`default_nettype wire

// File: tb/tb_rtc_barrido_lectura.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_barrido_lectura
// Purpose  : Self-checking bench for rtc_barrido_lectura (STEP_DIV = 4) with
//            an RTC bus model and a step-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_barrido_lectura;

    localparam int DIV = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       hold = 1'b0;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, ale;
    logic [5:0] addr;
    logic [7:0] s_l, m_l, h_l, d_l, me_l, a_l, st_l, mt_l, ht_l;
    logic       sweep_done, hold_ack;
`ifdef RTC_BCD_CHECK_EN
    logic       bcd_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    rtc_barrido_lectura #(.STEP_DIV(DIV), .ADDR_LAST(55)) dut (
        .clk(clk), .rst(rst), .hold(hold), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ale(ale),
        .addr(addr), .s_l(s_l), .m_l(m_l), .h_l(h_l), .d_l(d_l), .me_l(me_l),
        .a_l(a_l), .st_l(st_l), .mt_l(mt_l), .ht_l(ht_l),
        .sweep_done(sweep_done), .hold_ack(hold_ack)
`ifdef RTC_BCD_CHECK_EN
        , .bcd_err(bcd_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RTC bus model: latches the address during ALE, data is valid only
    // after rd_n has been low for 5 clocks; random junk otherwise.
    logic [7:0] mem [0:255];
    logic [7:0] lat  = 8'h00;
    logic [7:0] junk = 8'h00;
    int         rd_cnt = 0;
    always @(posedge clk) begin
        if (!cs_n && ale && !wr_n && ad_oe) lat <= ad_out;
        rd_cnt <= (!cs_n && !rd_n) ? rd_cnt + 1 : 0;
    end
    always @(negedge clk) junk <= 8'($urandom);
    assign ad_in = (!cs_n && !rd_n && rd_cnt >= 5) ? mem[lat] : junk;

    logic [7:0] dut_val [0:8];
    assign dut_val[0] = s_l;  assign dut_val[1] = m_l;  assign dut_val[2] = h_l;
    assign dut_val[3] = d_l;  assign dut_val[4] = me_l; assign dut_val[5] = a_l;
    assign dut_val[6] = st_l; assign dut_val[7] = mt_l; assign dut_val[8] = ht_l;

    int map_addr [0:8] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- step-level reference model ----------------
    int         m_addr = 0;
    int         m_cnt  = 0;
    bit         m_hold = 0;
    bit         m_sweep = 0;
    bit         m_bcd = 0;
    logic [7:0] m_val [0:8];

    initial begin : model
        int slot, ph;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_addr = 0; m_cnt = 0; m_hold = 0; m_sweep = 0; m_bcd = 0;
                for (int i = 0; i < 9; i++) m_val[i] = 8'h00;
            end else begin
                m_sweep = 0;
                m_bcd   = 0;
                if (m_hold) begin
                    if (!hold) m_hold = 0;
                end else if (m_cnt == DIV - 1) begin
                    slot = m_addr / 5;
                    ph   = m_addr % 5;
                    if (slot >= 1 && slot <= 9 && ph == 3) begin
`ifdef RTC_BCD_CHECK_EN
                        if (ad_in[7:4] > 4'd9 || ad_in[3:0] > 4'd9) m_bcd = 1;
                        else m_val[slot-1] = ad_in;
`else
                        m_val[slot-1] = ad_in;
`endif
                    end
                    if (m_addr == 55) begin
                        m_sweep = 1;
                        m_addr  = 0;
                    end else begin
                        m_addr = m_addr + 1;
                    end
                    m_cnt = 0;
                    if (hold && (m_addr % 5) == 0) m_hold = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin : cmp
        int slot, ph;
        bit rd_slot;
        logic [4:0] exp_bus;
        forever begin
            @(negedge clk);
            slot    = m_addr / 5;
            ph      = m_addr % 5;
            rd_slot = !m_hold && slot >= 1 && slot <= 9;
            // {cs_n, rd_n, wr_n, ale, ad_oe}
            exp_bus = {!(rd_slot && ph <= 3),
                       !(rd_slot && (ph == 2 || ph == 3)),
                       !(rd_slot && ph == 0),
                       rd_slot && ph == 0,
                       rd_slot && ph == 0};
            check("addr", 32'(addr), 32'(m_addr));
            check("hold_ack", 32'(hold_ack), 32'(m_hold));
            check("sweep_done", 32'(sweep_done), 32'(m_sweep));
            check("bus", 32'({cs_n, rd_n, wr_n, ale, ad_oe}), 32'(exp_bus));
            if (exp_bus[0]) check("ad_out", 32'(ad_out), 32'(map_addr[slot-1]));
            for (int i = 0; i < 9; i++)
                check($sformatf("val%0d", i), 32'(dut_val[i]), 32'(m_val[i]));
`ifdef RTC_BCD_CHECK_EN
            check("bcd_err", 32'(bcd_err), 32'(m_bcd));
`endif
        end
    end

    task automatic wait_addr(input int a, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (addr !== 6'(a) && n < budget);
        if (addr !== 6'(a)) begin
            checks++;
            errors++;
            $display("FAIL wait_addr: got addr %0d, expected %0d within %0d clks", addr, a, budget);
        end
    endtask

    task automatic wait_sweep(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sweep_done !== 1'b1 && n < 400);
        t = cyc;
        if (sweep_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_sweep: got no sweep_done, expected one within 400 clks");
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int t1, t2;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem['h21] = 8'h45;

        // Reset held for 3 clocks
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_strobes", 32'({cs_n, rd_n, wr_n, ad_oe}), 32'b1110);
        check("rst_s_l", 32'(s_l), 32'h00);
        check("rst_ht_l", 32'(ht_l), 32'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("addr_before_div", 32'(addr), 32'd0);
        @(negedge clk);
        check("addr_after_div", 32'(addr), 32'd1);

        // First read slot, register 0x21 returns 0x45
        wait_addr(5, 40);
        check("p0_ale_wr", 32'({ale, wr_n, ad_oe}), 32'b101);
        check("p0_ad_out", 32'(ad_out), 32'h21);
        wait_addr(7, 40);
        check("p2_rd_n", 32'(rd_n), 32'd0);
        wait_addr(8, 40);
        check("p3_rd_n", 32'(rd_n), 32'd0);
        wait_addr(9, 40);
        check("s_l_at9", 32'(s_l), 32'h45);
        wait_addr(10, 40);
        check("s_l_at10", 32'(s_l), 32'h45);

        // Full sweep with a known register map
        mem['h21] = 8'h11; mem['h22] = 8'h12; mem['h23] = 8'h13;
        mem['h24] = 8'h14; mem['h25] = 8'h15; mem['h26] = 8'h16;
        mem['h41] = 8'h59; mem['h42] = 8'h59; mem['h43] = 8'h23;
        wait_sweep(t1);
        wait_sweep(t2);
        check("sweep_period", 32'(t2 - t1), 32'd224);
        check("sw_s_l", 32'(s_l), 32'h11);   check("sw_m_l", 32'(m_l), 32'h12);
        check("sw_h_l", 32'(h_l), 32'h13);   check("sw_d_l", 32'(d_l), 32'h14);
        check("sw_me_l", 32'(me_l), 32'h15); check("sw_a_l", 32'(a_l), 32'h16);
        check("sw_st_l", 32'(st_l), 32'h59); check("sw_mt_l", 32'(mt_l), 32'h59);
        check("sw_ht_l", 32'(ht_l), 32'h23);

        // Hold requested mid-slot 3, granted at step 20
        wait_addr(17, 300);
        hold = 1'b1;
        wait_addr(20, 40);
        check("hold_ack_set", 32'(hold_ack), 32'd1);
        check("hold_bus_idle", 32'({cs_n, rd_n, wr_n, ad_oe}), 32'b1110);
        mem['h24] = 8'h77;
        repeat (10) @(negedge clk);
        check("hold_addr_frozen", 32'(addr), 32'd20);
        hold = 1'b0;
        @(negedge clk);
        check("hold_ack_clr", 32'(hold_ack), 32'd0);
        check("release_p0", 32'({addr, ale}), 32'({6'd20, 1'b1}));
        wait_addr(24, 40);
        check("d_l_after_hold", 32'(d_l), 32'h77);

        // BCD-invalid capture in slot 1
        mem['h21] = 8'h30;
        wait_addr(10, 300);
        check("s_l_30", 32'(s_l), 32'h30);
        mem['h21] = 8'h4A;
        wait_addr(9, 300);
`ifdef RTC_BCD_CHECK_EN
        check("s_l_bcd_kept", 32'(s_l), 32'h30);
        check("bcd_err_pulse", 32'(bcd_err), 32'd1);
`else
        check("s_l_raw", 32'(s_l), 32'h4A);
`endif

        // Randomized hold requests and register contents
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            if ($urandom_range(0, 49) == 0)
                mem[8'(map_addr[$urandom_range(0, 8)])] = 8'($urandom);
        end
        hold = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset during an active read strobe
        wait_addr(27, 400);
        check("pre_rst_rd_n", 32'(rd_n), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_strobes", 32'({rd_n, cs_n}), 32'b11);
        check("async_rst_addr", 32'(addr), 32'd0);
        check("async_rst_vals", 32'({s_l, d_l, me_l, ht_l}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_addr(12, 100);
        check("post_rst_s_l", 32'(s_l), 32'(mem['h21]));

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
